// File: rtl/otter_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage OTTER pipeline with a cached dmem.
// Produces operand forward selects, load-use/branch stalls, redirect flushes, and a
// freeze across multi-cycle dmem accesses, with saturating statistics and a sticky
// timeout flag.
module otter_hazard_ctrl #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned RA_W        = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_SRC*RA_W-1:0] rs_d,
  input  logic [NUM_SRC-1:0]      rs_d_used,
  input  logic [NUM_SRC*RA_W-1:0] rs_e,
  input  logic [NUM_SRC-1:0]      rs_e_used,
  input  logic [RA_W-1:0]         rd_e,
  input  logic [RA_W-1:0]         rd_m,
  input  logic [RA_W-1:0]         rd_w,
  input  logic                    regwrite_e,
  input  logic                    regwrite_m,
  input  logic                    regwrite_w,
  input  logic                    memread_e,
  input  logic                    memread_m,
  input  logic                    branch_d,
  input  logic                    redirect_d,
  input  logic                    dmem_req,
  input  logic                    dmem_ack,
  output logic [NUM_SRC*2-1:0]    fwd_d,
  output logic [NUM_SRC*2-1:0]    fwd_e,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    stall_e,
  output logic                    stall_m,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic                    bubble_w,
  output logic                    mem_wait,
  output logic [CNT_W-1:0]        miss_cnt,
  output logic [CNT_W-1:0]        lu_cnt,
  output logic                    timeout_err
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic             timeout_q, timeout_d;

  logic             lu, bh, hz, freeze;
  logic [RA_W-1:0]  rs_dv, rs_ev;

  // Per-operand forward selects plus load-use and branch-operand hazard detection.
  always_comb begin
    fwd_d = '0;
    fwd_e = '0;
    lu    = 1'b0;
    bh    = 1'b0;
    rs_dv = '0;
    rs_ev = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rs_dv = rs_d[i*RA_W +: RA_W];
      rs_ev = rs_e[i*RA_W +: RA_W];
      if (rs_d_used[i]) begin
        // A load in MEM only holds an address in alu_res, so it never forwards.
        if (regwrite_m && !memread_m && rd_m != '0 && rd_m == rs_dv) begin
          fwd_d[2*i +: 2] = 2'b10;
        end else if (regwrite_w && rd_w != '0 && rd_w == rs_dv) begin
          fwd_d[2*i +: 2] = 2'b01;
        end
        if (memread_e && regwrite_e && rd_e != '0 && rd_e == rs_dv) begin
          lu = 1'b1;
        end
        if (branch_d && ((regwrite_e && rd_e != '0 && rd_e == rs_dv) ||
                         (memread_m && rd_m != '0 && rd_m == rs_dv))) begin
          bh = 1'b1;
        end
      end
      if (rs_e_used[i]) begin
        if (regwrite_m && !memread_m && rd_m != '0 && rd_m == rs_ev) begin
          fwd_e[2*i +: 2] = 2'b10;
        end else if (regwrite_w && rd_w != '0 && rd_w == rs_ev) begin
          fwd_e[2*i +: 2] = 2'b01;
        end
      end
    end
    if (!RESET_N) begin
      fwd_d = '0;
      fwd_e = '0;
    end
  end

  assign hz     = lu | bh;
  assign freeze = dmem_req & ~dmem_ack;

  // Pipeline controls; a freeze dominates hazards, and everything is quiet in reset.
  always_comb begin
    stall_f  = RESET_N & (freeze | hz);
    stall_d  = RESET_N & (freeze | hz);
    stall_e  = RESET_N & freeze;
    stall_m  = RESET_N & freeze;
    bubble_w = RESET_N & freeze;
    flush_e  = RESET_N & hz & ~freeze;
    flush_d  = RESET_N & redirect_d & ~hz & ~freeze;
  end

  // Next-state: wait FSM, wait counter, saturating statistics and sticky timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    miss_cnt_d = miss_cnt_q;
    lu_cnt_d   = lu_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StRun:     if (freeze) state_d = StMemWait;
      // Leaves on ack or on an aborted access (req dropped).
      StMemWait: if (!freeze) state_d = StRun;
      default:   state_d = StRun;
    endcase
    if (freeze) begin
      // Counts frozen cycles; hitting the limit flags on the following frozen cycle.
      wait_cnt_d = (wait_cnt_q == WaitLimit) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
      if (wait_cnt_d == WaitLimit) timeout_d = 1'b1;
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end else if (hz && lu_cnt_q != '1) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      miss_cnt_q <= '0;
      lu_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      lu_cnt_q   <= lu_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_wait    = (state_q == StMemWait);
  assign miss_cnt    = miss_cnt_q;
  assign lu_cnt      = lu_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops and compares them on the falling edge (or on an explicit kick).
module tb_otter_hazard_ctrl;

  localparam int unsigned NS = 2;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  localparam int SigFwdD = 0, SigFwdE = 1, SigCtl = 2, SigWait = 3;
  localparam int SigMiss = 4, SigLu = 5, SigTo = 6;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}
  localparam logic [31:0] CNone   = 32'b0000000;
  localparam logic [31:0] CHz     = 32'b1100010;
  localparam logic [31:0] CFrz    = 32'b1111001;
  localparam logic [31:0] CFlushD = 32'b0000100;

  logic CLK = 1'b0;
  logic RESET_N;
  logic [NS*RW-1:0] rs_d, rs_e;
  logic [NS-1:0]    rs_d_used, rs_e_used;
  logic [RW-1:0]    rd_e, rd_m, rd_w;
  logic regwrite_e, regwrite_m, regwrite_w, memread_e, memread_m;
  logic branch_d, redirect_d, dmem_req, dmem_ack;
  logic [NS*2-1:0]  fwd_d, fwd_e;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w, mem_wait;
  logic [CW-1:0]    miss_cnt, lu_cnt;
  logic timeout_err;

  otter_hazard_ctrl #(
    .NUM_SRC(NS), .RA_W(RW), .CNT_W(CW), .MEM_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .rs_d(rs_d), .rs_d_used(rs_d_used), .rs_e(rs_e), .rs_e_used(rs_e_used),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memread_e(memread_e), .memread_m(memread_m),
    .branch_d(branch_d), .redirect_d(redirect_d),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .fwd_d(fwd_d), .fwd_e(fwd_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_w(bubble_w),
    .mem_wait(mem_wait), .miss_cnt(miss_cnt), .lu_cnt(lu_cnt), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event kick;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      SigFwdD: return 32'(fwd_d);
      SigFwdE: return 32'(fwd_e);
      SigCtl:  return 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w});
      SigWait: return 32'(mem_wait);
      SigMiss: return 32'(miss_cnt);
      SigLu:   return 32'(lu_cnt);
      default: return 32'(timeout_err);
    endcase
  endfunction

  task automatic push(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    rs_d = '0; rs_e = '0; rs_d_used = '0; rs_e_used = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memread_e = 0; memread_m = 0;
    branch_d = 0; redirect_d = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic drive_lu();
    memread_e = 1; rd_e = 5'd7; regwrite_e = 1; rs_d = {5'd7, 5'd0}; rs_d_used = 2'b10;
  endtask

  // Monitor: drains every expectation queued for the current sample point.
  always begin
    exp_t        e;
    logic [31:0] act;
    @(negedge CLK or kick);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = probe(e.sig);
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0;
    clr();
    // Hazard-causing inputs held in reset: outputs must stay quiet.
    rd_m = 5'd5; regwrite_m = 1; rs_e = {5'd0, 5'd5}; rs_e_used = 2'b01;
    drive_lu(); redirect_d = 1; dmem_req = 1;
    step();
    push("rst_fwd_e", SigFwdE, 0); push("rst_ctl", SigCtl, CNone);
    push("rst_wait", SigWait, 0);  push("rst_miss", SigMiss, 0);
    push("rst_lu", SigLu, 0);      push("rst_to", SigTo, 0);
    step(); RESET_N = 1'b1; clr();
    push("idle_ctl", SigCtl, CNone);

    // Forwarding priority and exclusions.
    step(); rd_m = 5'd5; regwrite_m = 1; rd_w = 5'd5; regwrite_w = 1;
    rs_e = {5'd0, 5'd5}; rs_e_used = 2'b01; rs_d = {5'd0, 5'd5}; rs_d_used = 2'b01;
    push("fwd_e_mem", SigFwdE, 32'h2); push("fwd_d_mem", SigFwdD, 32'h2);
    step(); rd_m = 5'd0;
    push("fwd_e_wb", SigFwdE, 32'h1);
    step(); rs_e = '0; rd_w = 5'd0;
    push("fwd_e_x0", SigFwdE, 32'h0);
    step(); clr(); rs_e = {5'd9, 5'd0}; rs_e_used = 2'b10;
    rd_m = 5'd9; regwrite_m = 1; memread_m = 1; rd_w = 5'd9; regwrite_w = 1;
    push("fwd_e_load_m", SigFwdE, 32'h4);
    step(); regwrite_w = 0;
    push("fwd_e_load_none", SigFwdE, 32'h0);

    // Load-use.
    step(); clr(); drive_lu();
    push("lu_ctl", SigCtl, CHz); push("lu_cnt0", SigLu, 0);
    step(); clr();
    push("lu_after_ctl", SigCtl, CNone); push("lu_cnt1", SigLu, 1);
    step(); drive_lu(); rs_d_used = 2'b01;
    push("lu_unused_ctl", SigCtl, CNone);
    step(); clr();
    push("lu_unused_cnt", SigLu, 1);

    // Branch hazard against a load in MEM, then forwarded from WB.
    step(); clr(); branch_d = 1; redirect_d = 1; rs_d = {5'd0, 5'd3}; rs_d_used = 2'b01;
    memread_m = 1; rd_m = 5'd3;
    push("bh_ctl", SigCtl, CHz); push("bh_fwd_d", SigFwdD, 0);
    step(); memread_m = 0; rd_m = 5'd0; rd_w = 5'd3; regwrite_w = 1;
    push("bh_wb_fwd_d", SigFwdD, 32'h1); push("bh_wb_ctl", SigCtl, CFlushD);
    push("bh_lu_cnt", SigLu, 2);

    // Miss freeze of four cycles with a concurrent load-use.
    step(); clr(); dmem_req = 1;
    push("frz1_ctl", SigCtl, CFrz); push("frz1_wait", SigWait, 0);
    for (int k = 2; k <= 4; k++) begin
      step(); drive_lu(); redirect_d = 1;
      push("frz_ctl", SigCtl, CFrz); push("frz_wait", SigWait, 1);
      push("frz_miss", SigMiss, 32'(k - 1));
    end
    step(); clr(); dmem_req = 1; dmem_ack = 1;
    push("ack_ctl", SigCtl, CNone); push("ack_wait", SigWait, 1);
    push("ack_miss", SigMiss, 4); push("ack_lu", SigLu, 2);
    step(); clr();
    push("run_wait", SigWait, 0); push("run_miss", SigMiss, 4);

    // Single-cycle hit: no freeze, no state change.
    step(); dmem_req = 1; dmem_ack = 1;
    push("hit_ctl", SigCtl, CNone); push("hit_wait", SigWait, 0);
    step(); clr();
    push("hit_wait2", SigWait, 0); push("hit_miss", SigMiss, 4);

    // Timeout after eight frozen cycles, sticky past the ack.
    for (int k = 1; k <= 8; k++) begin
      step(); clr(); dmem_req = 1;
      push("to_ctl", SigCtl, CFrz); push("to_flag", SigTo, (k >= 8) ? 32'd1 : 32'd0);
      push("to_miss", SigMiss, 32'(3 + k));
    end
    step(); dmem_ack = 1;
    push("to_ack_flag", SigTo, 1); push("to_ack_wait", SigWait, 1);
    step(); clr();
    push("to_sticky", SigTo, 1); push("to_wait0", SigWait, 0); push("to_miss12", SigMiss, 12);

    // Asynchronous reset in the middle of a wait.
    step(); dmem_req = 1;
    push("pre_rst_ctl", SigCtl, CFrz);
    step();
    push("pre_rst_wait", SigWait, 1);
    @(negedge CLK); #1;
    RESET_N = 1'b0;
    push("arst_wait", SigWait, 0); push("arst_to", SigTo, 0);
    push("arst_miss", SigMiss, 0); push("arst_ctl", SigCtl, CNone);
    #1; ->kick;

    // Long freeze from reset: miss counter saturates at 15.
    step(); RESET_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      push("sat_ctl", SigCtl, CFrz);
      push("sat_miss", SigMiss, (k - 1 > 15) ? 32'd15 : 32'(k - 1));
      push("sat_to", SigTo, (k >= 8) ? 32'd1 : 32'd0);
    end
    step(); dmem_ack = 1;
    push("sat_ack_miss", SigMiss, 15);
    step(); clr();
    push("sat_end_miss", SigMiss, 15); push("sat_end_wait", SigWait, 0);

    step();
    @(negedge CLK); #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined OTTER with a cached data memory.
- Generates per-operand forwarding selects for the decode and execute stages.
- Generates stall/flush controls for load-use and decode-resolved branch hazards.
- Freezes the pipeline across variable-latency dmem accesses (cache miss) via a req/ack handshake, and keeps miss statistics and a sticky timeout flag.

Parameters:
- NUM_SRC, 2, source operands per instruction (1..3).
- RA_W, 5, register address width.
- CNT_W, 16, width of the saturating stall/miss counters.
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles that set the timeout error (≥2).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- rs_d  in  NUM_SRC*RA_W  decode source addresses; operand i in bits [i*RA_W +: RA_W].
- rs_d_used  in  NUM_SRC  decode operand i actually read.
- rs_e  in  NUM_SRC*RA_W  execute source addresses.
- rs_e_used  in  NUM_SRC  execute operand i actually read.
- rd_e, rd_m, rd_w  in  RA_W  destination addresses, EX/MEM/WB.
- regwrite_e, regwrite_m, regwrite_w  in  1  writes register file.
- memread_e, memread_m  in  1  instruction is a load.
- branch_d  in  1  decode holds branch/JALR needing operands now.
- redirect_d  in  1  decode resolved a taken branch/jump.
- dmem_req  in  1  MEM stage has a valid dmem access.
- dmem_ack  in  1  dmem data/write complete this cycle.
- fwd_d  out  NUM_SRC*2  decode forward select per operand.
- fwd_e  out  NUM_SRC*2  execute forward select per operand.
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / IF_DE / DE_EX / EX_MEM.
- flush_d, flush_e, bubble_w  out  1  zero IF_DE / DE_EX / MEM_WB.
- mem_wait  out  1  FSM in MEM_WAIT.
- miss_cnt  out  CNT_W  total cycles spent frozen.
- lu_cnt  out  CNT_W  total load-use/branch stall cycles.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Forward encoding: 00 register file, 01 WB result, 10 MEM alu_res.
  - MEM beats WB.
  - A match needs the operand's used bit, regwrite of the producer, and rd≠0.
  - Address 0 is never forwarded.
  - A MEM-stage producer with memread_m does not forward (its alu_res is an address); the result falls to WB or 00.
- Load-use (lu): memread_e & regwrite_e & rd_e≠0 & rd_e matches any used decode source.
- Branch hazard (bh): branch_d & ((regwrite_e & rd_e≠0 & rd_e matches a used rs_d) | (memread_m & rd_m≠0 & rd_m matches a used rs_d)).
- hz = lu | bh. When hz and not frozen: stall_f = stall_d = 1, flush_e = 1, lu_cnt += 1 (saturating).
- freeze = dmem_req & ~dmem_ack. When freeze: stall_f = stall_d = stall_e = stall_m = 1, bubble_w = 1.
  - flush_e = 0, flush_d = 0 and lu_cnt is unchanged; freeze dominates hz.
- flush_d = redirect_d & ~hz & ~freeze. A redirect is acted on only in the cycle the decode stage advances.
- All stall/flush outputs are combinational from current inputs and state.
- FSM, two states:
  - RUN → MEM_WAIT when freeze.
  - MEM_WAIT → RUN when dmem_ack; that cycle has no freeze and the pipeline advances.
  - MEM_WAIT stays while dmem_req & ~dmem_ack.
  - dmem_req dropping in MEM_WAIT (aborted access) → RUN.
- mem_wait = (state == MEM_WAIT).
- Wait counter (internal): cleared on entry to RUN; increments each cycle in MEM_WAIT.
  - Reaching MEM_TIMEOUT-1 while still frozen sets timeout_err.
  - timeout_err stays set until reset.
- miss_cnt += 1 each freeze cycle. Both counters saturate at all-ones and never wrap.
- A 1-cycle hit (req & ack same cycle) causes no freeze and no state change.
- Reset (RESET_N low, async): state RUN, counters 0, timeout_err 0.
  - While in reset, all stall/flush/bubble outputs are forced 0 and fwd_* are 00.
  - Reset mid-MEM_WAIT aborts immediately.

Test Plan:
- Forwarding: rd_m=5 regwrite_m=1 and rd_w=5 regwrite_w=1, rs_e op0=5 used → fwd_e[1:0]=10. Set rd_m=0 → 01. Set rs_e=0 → 00.
- Load-use: memread_e=1 rd_e=7 regwrite_e=1, rs_d op1=7 used → stall_f=stall_d=flush_e=1 for 1 cycle, lu_cnt 0→1. Same with rs_d_used[1]=0 → no stall.
- Branch hazard: branch_d=1, rs_d op0=3, memread_m=1 rd_m=3 → stall asserted, flush_d=0 even with redirect_d=1. Next cycle (producer in WB) → fwd_d=01, flush_d=1.
- Miss freeze: dmem_req=1 for 4 cycles with dmem_ack=0 then 1 → mem_wait high 4 cycles, all four stalls plus bubble_w high 4 cycles, miss_cnt=4. Concurrent load-use during the freeze leaves flush_e=0.
- Timeout: MEM_TIMEOUT=8, req held, ack never asserted → timeout_err rises on the 8th frozen cycle and stays 1 after ack. Pulsing RESET_N low clears everything asynchronously mid-cycle.
- Saturation: CNT_W=4, freeze 20 cycles → miss_cnt=15.
